controle_medicoes_hcsr04: RTL and testbench

Scheduler/sequencer that drives the ultrasonic sensor interface block.
- Issues periodic measurement requests and waits for completion, with a timeout.
- Latches each distance and produces a 2^L-sample average.
- Flags repeated sensor failures.
- Sits between the game/application FSM and the sensor interface, so the rest of the design sees only averaged, validated distances.

---
 rtl/controle_medicoes_hcsr04_pkg.sv | 21 ++
 rtl/controle_medicoes_hcsr04_edge_detector.sv | 20 ++
 rtl/controle_medicoes_hcsr04.sv | 153 +++++++++++++++
 tb/tb_controle_medicoes_hcsr04.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/controle_medicoes_hcsr04_pkg.sv
// controle_medicoes_hcsr04 shared definitions
// state encodings, widths and small helpers
package controle_medicoes_hcsr04_pkg;

   localparam int LARG_MEDIDA = 12;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      ESPERA   = 4'd1,
      DISPARA  = 4'd2,
      AGUARDA  = 4'd3,
      ARMAZENA = 4'd4,
      CALCULA  = 4'd5,
      FALHA    = 4'd6
   } estado_t;

   function automatic int maior(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controle_medicoes_hcsr04_edge_detector.sv
// edge_detector: rising-edge pulse of a level input
// active-high async reset, pulso is combinational
module edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic sinal,
   output logic pulso
);

   logic r_sinal;

   // previous value of the input
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_sinal <= 1'b0;
      else       r_sinal <= sinal;
   end

   assign pulso = sinal & ~r_sinal;

endmodule

// File: rtl/controle_medicoes_hcsr04.sv
// controle_medicoes_hcsr04: HC-SR04 measurement scheduler
// periodic requests, timeout, 2^L averaging, failure flag
module controle_medicoes_hcsr04
   import controle_medicoes_hcsr04_pkg::*;
#(
   parameter int PERIODO    = 3000000,
   parameter int TIMEOUT    = 2500000,
   parameter int L          = 2,
   parameter int MAX_FALHAS = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ligar,
   input  logic                   pronto_sensor,
   input  logic [LARG_MEDIDA-1:0] medida_sensor,
   output logic                   medir,
   output logic [LARG_MEDIDA-1:0] ultima_medida,
   output logic [LARG_MEDIDA-1:0] media,
   output logic                   media_valida,
   output logic                   erro,
   output logic [3:0]             db_estado
);

   localparam int LARG_CONT = $clog2(maior(PERIODO, TIMEOUT));
   localparam int LARG_ACC  = LARG_MEDIDA + L;
   localparam int LARG_N    = L + 1;
   localparam int LARG_F    = $clog2(MAX_FALHAS + 1);

   localparam logic [LARG_CONT-1:0] C_FIM_PERIODO =
      LARG_CONT'(PERIODO - 1);
   localparam logic [LARG_CONT-1:0] C_FIM_TIMEOUT =
      LARG_CONT'(TIMEOUT - 1);
   localparam logic [LARG_N-1:0] C_N_AMOSTRAS =
      LARG_N'(1 << L);
   localparam logic [LARG_F-1:0] C_MAX_F =
      LARG_F'(MAX_FALHAS);

   estado_t                r_estado;
   estado_t                w_prox;
   logic                   w_evento;
   logic                   w_reset_alto;
   logic [LARG_CONT-1:0]   r_cont;
   logic [LARG_ACC-1:0]    r_acc;
   logic [LARG_N-1:0]      r_n;
   logic [LARG_N-1:0]      w_n_prox;
   logic [LARG_F-1:0]      r_falhas;
   logic [LARG_F-1:0]      w_falhas_prox;
   logic [LARG_MEDIDA-1:0] r_amostra;
   logic [LARG_MEDIDA-1:0] r_ultima;
   logic [LARG_MEDIDA-1:0] r_media;
   logic                   r_erro;

   assign w_reset_alto = ~reset;

   edge_detector u_borda_pronto (
      .clock (clock),
      .reset (w_reset_alto),
      .sinal (pronto_sensor),
      .pulso (w_evento)
   );

   assign w_n_prox      = r_n + LARG_N'(1);
   assign w_falhas_prox = (r_falhas == C_MAX_F) ?
                          r_falhas : r_falhas + LARG_F'(1);

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_estado <= INICIAL;
      else        r_estado <= w_prox;
   end

   // next state; dropping ligar always wins
   always_comb begin
      w_prox = r_estado;
      if (r_estado != INICIAL && !ligar) begin
         w_prox = INICIAL;
      end else begin
         unique case (r_estado)
            INICIAL:  if (ligar) w_prox = DISPARA;
            ESPERA:   if (r_cont == C_FIM_PERIODO) w_prox = DISPARA;
            DISPARA:  w_prox = AGUARDA;
            AGUARDA: begin
               if (w_evento)                    w_prox = ARMAZENA;
               else if (r_cont == C_FIM_TIMEOUT) w_prox = FALHA;
            end
            ARMAZENA: begin
               if (w_n_prox == C_N_AMOSTRAS) w_prox = CALCULA;
               else                          w_prox = ESPERA;
            end
            CALCULA:  w_prox = ESPERA;
            FALHA:    w_prox = ESPERA;
            default:  w_prox = INICIAL;
         endcase
      end
   end

   // shared timer, accumulator, counters and result registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cont    <= '0;
         r_acc     <= '0;
         r_n       <= '0;
         r_falhas  <= '0;
         r_amostra <= '0;
         r_ultima  <= '0;
         r_media   <= '0;
         r_erro    <= 1'b0;
      end else if (!ligar) begin
         r_cont   <= '0;
         r_acc    <= '0;
         r_n      <= '0;
         r_falhas <= '0;
         r_erro   <= 1'b0;
      end else begin
         unique case (r_estado)
            ESPERA:  r_cont <= r_cont + LARG_CONT'(1);
            DISPARA: r_cont <= '0;
            AGUARDA: begin
               r_cont <= r_cont + LARG_CONT'(1);
               if (w_evento) r_amostra <= medida_sensor;
            end
            ARMAZENA: begin
               r_ultima <= r_amostra;
               r_acc    <= r_acc + {{L{1'b0}}, r_amostra};
               r_n      <= w_n_prox;
               r_falhas <= '0;
               r_erro   <= 1'b0;
               r_cont   <= '0;
            end
            CALCULA: begin
               r_media <= r_acc[LARG_ACC-1:L];
               r_acc   <= '0;
               r_n     <= '0;
               r_cont  <= '0;
            end
            FALHA: begin
               r_falhas <= w_falhas_prox;
               if (w_falhas_prox == C_MAX_F) r_erro <= 1'b1;
               r_cont <= '0;
            end
            default: ;
         endcase
      end
   end

   assign medir         = (r_estado == DISPARA);
   assign media_valida  = (r_estado == CALCULA);
   assign db_estado     = r_estado;
   assign ultima_medida = r_ultima;
   assign media         = r_media;
   assign erro          = r_erro;

endmodule

// File: tb/tb_controle_medicoes_hcsr04.sv
// tb_controle_medicoes_hcsr04: directed self-checking bench
// PERIODO=20 TIMEOUT=10 L=2 MAX_FALHAS=2
module tb_controle_medicoes_hcsr04;
   import controle_medicoes_hcsr04_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ligar;
   logic        pronto_sensor;
   logic [11:0] medida_sensor;
   logic        medir;
   logic [11:0] ultima_medida;
   logic [11:0] media;
   logic        media_valida;
   logic        erro;
   logic [3:0]  db_estado;

   int n_comp = 0;
   int n_err  = 0;
   int ciclos;

   controle_medicoes_hcsr04 #(
      .PERIODO    (20),
      .TIMEOUT    (10),
      .L          (2),
      .MAX_FALHAS (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ligar         (ligar),
      .pronto_sensor (pronto_sensor),
      .medida_sensor (medida_sensor),
      .medir         (medir),
      .ultima_medida (ultima_medida),
      .media         (media),
      .media_valida  (media_valida),
      .erro          (erro),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   task automatic checar(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] esp);
      n_comp++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic esperar_medir(input string tag, output int c);
      c = 0;
      while (!medir && c < 100) begin
         tick(1);
         c++;
      end
      if (!medir) checar(tag, 32'(medir), 1);
   endtask

   // pronto rises so that it is sampled atraso edges after DISPARA
   task automatic amostra(input string tag, input logic [11:0] v,
                          input int atraso, input bit manter);
      tick(atraso - 1);
      pronto_sensor = 1'b1;
      medida_sensor = v;
      tick(1);
      checar(tag, db_estado, ARMAZENA);
      if (!manter) pronto_sensor = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      ligar = 1'b0;
      pronto_sensor = 1'b0;
      medida_sensor = '0;
      tick(2);
      checar("rst_estado", db_estado, INICIAL);
      checar("rst_medir", medir, 0);
      checar("rst_valida", media_valida, 0);
      checar("rst_erro", erro, 0);
      checar("rst_ultima", ultima_medida, 0);
      checar("rst_media", media, 0);

      // 1: first request, first sample, spacing
      reset = 1'b1;
      ligar = 1'b1;
      tick(1);
      checar("t1_disp", db_estado, DISPARA);
      checar("t1_medir", medir, 1);
      tick(1);
      checar("t1_medir_baixo", medir, 0);
      checar("t1_aguarda", db_estado, AGUARDA);
      amostra("t1_arm", 12'd100, 4, 0);
      tick(1);
      checar("t1_ultima", ultima_medida, 100);
      checar("t1_espera", db_estado, ESPERA);
      esperar_medir("t1_medir_to", ciclos);
      checar("t1_espaco", 32'(ciclos + 1), 21);

      // 2: four samples, average
      amostra("t2_arm2", 12'd101, 5, 0);
      esperar_medir("t2_medir_to", ciclos);
      amostra("t2_arm3", 12'd102, 3, 0);
      esperar_medir("t2_medir_to", ciclos);
      amostra("t2_arm4", 12'd105, 7, 0);
      tick(1);
      checar("t2_calc", db_estado, CALCULA);
      checar("t2_valida", media_valida, 1);
      tick(1);
      checar("t2_media", media, 102);
      checar("t2_valida_baixo", media_valida, 0);

      // 3: timeouts raise erro, success clears it
      esperar_medir("t3_medir_to", ciclos);
      tick(10);
      checar("t3_aguarda", db_estado, AGUARDA);
      tick(1);
      checar("t3_falha", db_estado, FALHA);
      tick(1);
      checar("t3_erro0", erro, 0);
      esperar_medir("t3_medir_to", ciclos);
      tick(11);
      checar("t3_falha2", db_estado, FALHA);
      tick(1);
      checar("t3_erro1", erro, 1);
      esperar_medir("t3_medir_to", ciclos);
      amostra("t3_arm", 12'd50, 2, 0);
      tick(1);
      checar("t3_erro_lim", erro, 0);
      checar("t3_ultima", ultima_medida, 50);

      // 4: event on the timeout cycle wins
      esperar_medir("t4_medir_to", ciclos);
      amostra("t4_empate", 12'd60, 11, 0);
      tick(1);
      checar("t4_ultima", ultima_medida, 60);
      checar("t4_erro", erro, 0);

      // 5: ligar dropped with 2 samples held
      esperar_medir("t5_medir_to", ciclos);
      tick(3);
      ligar = 1'b0;
      tick(1);
      checar("t5_inicial", db_estado, INICIAL);
      checar("t5_media_ret", media, 102);
      pronto_sensor = 1'b1;
      medida_sensor = 12'd999;
      tick(2);
      checar("t5_ignora", db_estado, INICIAL);
      checar("t5_ultima_ret", ultima_medida, 60);
      pronto_sensor = 1'b0;
      tick(1);
      ligar = 1'b1;
      tick(1);
      checar("t5_medir", medir, 1);
      amostra("t5_arm1", 12'd200, 4, 0);
      esperar_medir("t5_medir_to", ciclos);
      amostra("t5_arm2", 12'd204, 4, 0);
      tick(1);
      checar("t5_sem_calc", db_estado, ESPERA);
      esperar_medir("t5_medir_to", ciclos);
      amostra("t5_arm3", 12'd208, 4, 0);
      tick(1);
      checar("t5_sem_calc3", db_estado, ESPERA);
      esperar_medir("t5_medir_to", ciclos);
      amostra("t5_arm4", 12'd212, 4, 0);
      tick(1);
      checar("t5_valida", media_valida, 1);
      tick(1);
      checar("t5_media", media, 206);

      // 6: async reset mid-AGUARDA, held pronto
      esperar_medir("t6_medir_to", ciclos);
      tick(2);
      #3 reset = 1'b0;
      #1;
      checar("t6_estado", db_estado, INICIAL);
      checar("t6_ultima", ultima_medida, 0);
      checar("t6_media", media, 0);
      checar("t6_erro", erro, 0);
      checar("t6_medir", medir, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      tick(1);
      checar("t6_disp", db_estado, DISPARA);
      amostra("t6_arm", 12'd77, 3, 1);
      esperar_medir("t6_medir_to", ciclos);
      medida_sensor = 12'd88;
      tick(11);
      checar("t6_alto_falha", db_estado, FALHA);
      tick(1);
      checar("t6_ultima_77", ultima_medida, 77);
      pronto_sensor = 1'b0;
      esperar_medir("t6_medir_to", ciclos);
      amostra("t6_arm2", 12'd90, 2, 0);
      tick(1);
      checar("t6_ultima_90", ultima_medida, 90);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_comp, n_err);
      $finish;
   end

endmodule
